// File: rtl/calc_pkg.sv
// Shared definitions for the parametrised sequential calculator.
//   op_e        : operation encodings seen on the op port
//   state_e     : handshake FSM states
//   cnt_width() : iteration counter width needed to count 0..WIDTH
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Unsigned WIDTH-iteration shift-add multiplier / restoring divider.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load opa/opb and begin WIDTH iterations on the next edges
//   mode          : 0 multiply, 1 divide
//   opa, opb      : multiplier/multiplicand or dividend/divisor (magnitudes)
//   done          : high during the last iteration cycle
//   prod          : 2*WIDTH product (valid after the last iteration)
//   quot, rem     : quotient / remainder (valid after the last iteration)
module seq_muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem
);

  // acc holds {high, low}: for MUL {partial sum, remaining multiplier bits},
  // for DIV {partial remainder, dividend bits shifting into quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opd;
  logic               mode_q;
  logic               run;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;

  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd & {WIDTH{acc[0]}}};
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, opd};
    acc_nxt = acc;
    if (mode_q) begin
      // Negative trial: keep the shifted remainder, quotient bit 0.
      if (trial[WIDTH+1]) acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end
  end

  assign done = run && (cnt == CNT_W'(WIDTH - 1));
  assign prod = acc;
  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      opd    <= '0;
      mode_q <= 1'b0;
      run    <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= {{WIDTH{1'b0}}, opa};
      opd    <= opb;
      mode_q <= mode;
      run    <= 1'b1;
      cnt    <= '0;
    end else if (run) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// Parametrised multi-cycle integer calculator (ADD/SUB/MUL/DIV, signed or
// unsigned per operation) with valid/ready handshakes on both sides.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : request handshake (in_ready only in IDLE)
//   op, is_signed, a, b  : operation, signedness, operands (captured at accept)
//   out_valid, out_ready : result handshake (out_valid only in DONE)
//   result, remainder    : result / DIV remainder (0 for non-DIV)
//   overflow             : result not representable
//   div_by_zero          : DIV with b==0
//   busy                 : high in CALC or FIX
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready high
// CALC  | ADD/SUB/div-by-zero resolve in one cycle; MUL/DIV iterate WIDTH times
// FIX   | apply operand signs to MUL/DIV magnitudes, form flags
// DONE  | result held until out_ready
module calc_core_param
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             busy
);

  state_e             state_q, state_d;
  op_e                op_q;
  logic               sgn_q;
  logic [WIDTH-1:0]   a_q, b_q;

  logic               accept;
  logic               mu_start, mu_done;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] mu_prod;
  logic [WIDTH-1:0]   mu_quot, mu_rem;

  logic [WIDTH:0]     sum_ext, dif_ext;
  logic [WIDTH-1:0]   as_res;
  logic               as_ovf;
  logic               neg_p, neg_a, b_zero;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     prod_top;
  logic               mul_ovf, div_ovf;
  logic [WIDTH-1:0]   q_s, r_s;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign accept    = in_valid && in_ready;

  // Magnitudes come straight from the ports so the iterative unit is loaded
  // on the acceptance edge and its WIDTH iterations fill the CALC cycles.
  assign mag_a    = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b    = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign mu_start = accept && (op[1] && !(op[0] && (b == '0)));

  seq_muldiv_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (mu_start),
    .mode  (op[0]),
    .opa   (mag_a),
    .opb   (mag_b),
    .done  (mu_done),
    .prod  (mu_prod),
    .quot  (mu_quot),
    .rem   (mu_rem)
  );

  always_comb begin
    b_zero  = (b_q == '0);
    neg_a   = sgn_q && a_q[WIDTH-1];
    neg_p   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    dif_ext = {1'b0, a_q} - {1'b0, b_q};
    if (op_q == OP_SUB) begin
      as_res = dif_ext[WIDTH-1:0];
      as_ovf = sgn_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (as_res[WIDTH-1] != a_q[WIDTH-1]))
                     : dif_ext[WIDTH];
    end else begin
      as_res = sum_ext[WIDTH-1:0];
      as_ovf = sgn_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (as_res[WIDTH-1] != a_q[WIDTH-1]))
                     : sum_ext[WIDTH];
    end
    prod_s   = neg_p ? (~mu_prod + 1'b1) : mu_prod;
    prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    mul_ovf  = sgn_q ? !((&prod_top) || (~|prod_top)) : (|mu_prod[2*WIDTH-1:WIDTH]);
    q_s      = neg_p ? (~mu_quot + 1'b1) : mu_quot;
    r_s      = neg_a ? (~mu_rem + 1'b1) : mu_rem;
    // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
    div_ovf  = sgn_q && !neg_p && mu_quot[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: begin
        if (!op_q[1] || (op_q == OP_DIV && b_zero)) state_d = DONE;
        else if (mu_done)                            state_d = FIX;
      end
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_ADD;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          op_q        <= op_e'(op);
          sgn_q       <= is_signed;
          a_q         <= a;
          b_q         <= b;
          overflow    <= 1'b0;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          if (!op_q[1]) begin
            result    <= as_res;
            remainder <= '0;
            overflow  <= as_ovf;
          end else if (op_q == OP_DIV && b_zero) begin
            result      <= '1;
            remainder   <= a_q;
            overflow    <= 1'b0;
            div_by_zero <= 1'b1;
          end
        end
        FIX: begin
          if (op_q == OP_MUL) begin
            result    <= prod_s[WIDTH-1:0];
            remainder <= '0;
            overflow  <= mul_ovf;
          end else begin
            result    <= q_s;
            remainder <= r_s;
            overflow  <= div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core_param.sv
module tb_calc_core_param;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result, remainder;
  logic         overflow, div_by_zero, busy;

  int ntests = 0;
  int nfail  = 0;

  calc_core_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: operate on the mathematical integer values and
  // decide representability against the WIDTH-bit range.
  function automatic void model(input logic [1:0] o, input logic s,
                                input logic [W-1:0] av, input logic [W-1:0] bv,
                                output logic [W-1:0] r, output logic [W-1:0] rm,
                                output logic ov, output logic dz, output int lat);
    longint sa, sb, res, rr;
    longint maxs, mins, maxu;
    maxs = (longint'(1) <<< (W-1)) - 1;
    mins = -(longint'(1) <<< (W-1));
    maxu = (longint'(1) <<< W) - 1;
    sa = s ? longint'($signed(av)) : longint'(av);
    sb = s ? longint'($signed(bv)) : longint'(bv);
    rr = 0; dz = 1'b0; res = 0;
    case (o)
      2'b00: res = sa + sb;
      2'b01: res = sa - sb;
      2'b10: res = sa * sb;
      default: begin
        if (sb == 0) dz = 1'b1;
        else begin res = sa / sb; rr = sa % sb; end
      end
    endcase
    if (dz) begin
      r = '1; rm = av; ov = 1'b0; lat = 2;
    end else begin
      r  = res[W-1:0];
      rm = rr[W-1:0];
      ov = s ? (res > maxs || res < mins) : (res > maxu || res < 0);
      lat = o[1] ? W + 2 : 2;
    end
  endfunction

  // Issue one op, leave the DUT in DONE with out_ready low, check everything.
  task automatic run_op(input logic [1:0] o, input logic s,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic [W-1:0] erm,
                        input logic eo, input logic ed, input int el, input string tag);
    int n, nb;
    @(negedge clk);
    chk({tag, " in_ready_before"}, in_ready, 1);
    op = o; is_signed = s; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom); is_signed = 1'($urandom);
    chk({tag, " accept_clears"}, {out_valid, overflow, div_by_zero}, 0);
    n = 1; nb = 0;
    while (!out_valid && n < 100) begin
      nb += int'(busy);
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      ntests++; nfail++;
      $display("FAIL %s timeout: out_valid never rose within %0d edges", tag, n);
      return;
    end
    chk({tag, " latency"}, n, el);
    chk({tag, " busy_cycles"}, nb, el - 1);
    chk({tag, " result"}, result, er);
    chk({tag, " remainder"}, remainder, erm);
    chk({tag, " overflow"}, overflow, eo);
    chk({tag, " div_by_zero"}, div_by_zero, ed);
    chk({tag, " done_flags"}, {in_ready, busy}, 0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " post_release"}, {in_ready, out_valid, busy}, 3'b100);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] er, erm, hr, hrm;
    logic eo, ed, ho, hd;
    int el;
    logic [1:0] ro;
    logic rs;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{OP_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[1]  = '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[2]  = '{OP_MUL, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0000, 1'b0, 1'b0, 18};
    vecs[3]  = '{OP_MUL, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0, 18};
    vecs[4]  = '{OP_DIV, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[5]  = '{OP_DIV, 1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 18};
    vecs[6]  = '{OP_DIV, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 2};
    vecs[7]  = '{OP_DIV, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b0, 18};
    vecs[8]  = '{OP_SUB, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 2};
    vecs[9]  = '{OP_SUB, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 2};
    vecs[10] = '{OP_MUL, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b0, 18};
    vecs[11] = '{OP_ADD, 1'b1, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0, 1'b0, 2};
    vecs[12] = '{OP_DIV, 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 18};
    vecs[13] = '{OP_MUL, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 18};
    vecs[14] = '{OP_DIV, 1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, busy, result, remainder, overflow, div_by_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].rem,
             vecs[i].ovf, vecs[i].dbz, vecs[i].lat, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Randomized against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom);
      rs = 1'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 16'h8000; rb = 16'hFFFF; end
        2: rb = W'($urandom_range(1, 3));
        default: ;
      endcase
      model(ro, rs, ra, rb, er, erm, eo, ed, el);
      run_op(ro, rs, ra, rb, er, erm, eo, ed, el,
             $sformatf("rnd%0d op%0d s%0d %h_%h", i, ro, rs, ra, rb));
      drain($sformatf("rnd%0d", i));
    end

    // Backpressure: DONE holds while new requests arrive
    model(OP_MUL, 1'b1, 16'hFFFD, 16'h0005, hr, hrm, ho, hd, el);
    run_op(OP_MUL, 1'b1, 16'hFFFD, 16'h0005, hr, hrm, ho, hd, el, "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      op = 2'b00; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c),
          {out_valid, in_ready, busy, result, remainder, overflow, div_by_zero},
          {1'b1, 1'b0, 1'b0, hr, hrm, ho, hd});
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain("bp");
    @(posedge clk); #1;
    chk("bp_no_new_op", {busy, out_valid, in_ready}, 3'b001);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = OP_MUL; is_signed = 1'b0; a = 16'd3; b = 16'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midop_reset", {out_valid, busy, result, remainder, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midop_reset_in_ready", {in_ready, busy}, 2'b10);
    repeat (20) begin
      @(posedge clk); #1;
      chk("midop_reset_discarded", {out_valid, busy}, 0);
    end
    run_op(OP_ADD, 1'b0, 16'd3, 16'd4, 16'd7, 16'd0, 1'b0, 1'b0, 2, "post_reset_add");
    drain("post_reset_add");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
Parametrised multi-cycle integer calculator: ADD, SUB, MUL (shift-add) and DIV (restoring), selectable signed or unsigned per operation, with result and remainder outputs.
Next generation of the fixed 16-bit sequential calculator.
- Adds WIDTH generalisation, signed mode and valid/ready handshakes on both sides.
- Corrects overflow for the current result and latches op at acceptance.
Sits between the command front-end and the result/status register file.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock; reset is synchronous and active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept (high only in IDLE)
op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
is_signed  input  1  1: two's-complement operands, 0: unsigned
a  input  WIDTH  first operand / dividend
b  input  WIDTH  second operand / divisor
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  WIDTH  sum/difference/low product/quotient
remainder  output  WIDTH  DIV remainder, 0 for other ops
overflow  output  1  result not representable
div_by_zero  output  1  DIV with b==0
busy  output  1  high in CALC or FIX

Behaviour:
- Reset (rst high at clk edge, any state incl. mid-op):
  - state=IDLE.
  - result, remainder, overflow, div_by_zero, out_valid, busy all 0.
  - Counter and internal registers cleared; in-flight op discarded.
  - in_ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE -> CALC on in_valid&&in_ready.
  - CALC -> DONE for ADD/SUB and for DIV with b==0, after 1 cycle.
  - CALC -> FIX for MUL/DIV after WIDTH iterations (counter 0..WIDTH-1).
  - FIX -> DONE after 1 cycle.
  - DONE -> IDLE on out_ready.
- Acceptance edge:
  - Captures a, b, op, is_signed.
  - Clears overflow, div_by_zero and out_valid.
  - Later changes on the inputs have no effect.
- Latency, acceptance edge to out_valid high:
  - ADD/SUB/div-by-zero: 2 edges.
  - MUL/DIV: WIDTH+2 edges.
- out_valid=(state==DONE). result/remainder/flags stay stable while out_valid&&!out_ready. in_valid is ignored outside IDLE.
- No same-cycle bypass: in_ready rises the cycle after the out_valid&&out_ready edge. Max throughput is one op per latency+1 cycles.
- ADD/SUB:
  - Wrap modulo 2^WIDTH.
  - Signed overflow is computed from the newly formed result, not the previous one.
  - Unsigned: overflow = carry out (ADD) or borrow (SUB).
- MUL:
  - In signed mode, iterate on magnitudes; negate the 2*WIDTH product in FIX if operand signs differ.
  - result = low WIDTH bits.
  - Overflow, unsigned: upper WIDTH bits nonzero.
  - Overflow, signed: product bits [2W-1:W-1] not all equal.
- DIV:
  - Restoring, one quotient bit per cycle, MSB first, on magnitudes.
  - Truncates toward zero; remainder takes the sign of the dividend (FIX applies signs).
  - b==0: div_by_zero=1, result=all ones, remainder=a, overflow=0, no iterations.
  - Signed MIN/-1: result=MIN, remainder=0, overflow=1.
- busy is low in IDLE and DONE.

Decomposition:
- Shared package calc_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV.
  - State encodings IDLE/CALC/FIX/DONE.
  - Localparam helper for CNT_W.
- One natural sub-module, seq_muldiv_unit:
  - Unsigned WIDTH-iteration shift-add multiplier / restoring divider.
  - Interface: start, mode, magnitudes in; done, 2*WIDTH product or quotient/remainder out.
- The top keeps the handshake FSM, sign handling and flags.

Test Plan:
1. Signed ADD a=0x7FFF, b=0x0001 -> result 0x8000, overflow=1, out_valid 2 edges after accept. Unsigned ADD 0xFFFF+0x0001 -> 0x0000, overflow=1.
2. Signed MUL a=0xFFFD(-3), b=0x0005 -> result 0xFFF1, overflow=0, out_valid 18 edges after accept, busy high 17 cycles. Unsigned MUL 0x0100*0x0100 -> 0x0000, overflow=1.
3. Signed DIV -7/2 (0xFFF9, 0x0002) -> result 0xFFFD, remainder 0xFFFF. Unsigned DIV 100/7 -> result 14, remainder 2.
4. DIV a=0x1234, b=0 -> div_by_zero=1, result 0xFFFF, remainder 0x1234, latency 2. Signed DIV 0x8000/0xFFFF -> result 0x8000, overflow=1, remainder 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid toggles with new operands -> outputs unchanged, in_ready=0, no new op started. out_ready=1 -> IDLE, in_ready=1 next cycle.
6. Assert rst at MUL iteration 7 -> next cycle out_valid=0, busy=0, result=0. After rst deasserts, in_ready=1 and ADD 3+4 returns 7 with normal latency.
